id_ex_stage_reg: RTL and testbench

Pipeline register between the Instruction Decode stage and the Execute stage. Each cycle it captures the decoded control word, the register-file operands (`reg1`/`reg2` read from the register file) and the instruction fields. It presents them, registered, to the EX stage. It also implements the pipeline's freeze (memory stall), flush (taken branch) and bubble (hazard) rules for this boundary.

---
 rtl/id_ex_stage_reg_pkg.sv | 31 +++
 rtl/id_ex_stage_reg_pipe_field_reg.sv | 26 ++
 rtl/id_ex_stage_reg.sv | 118 +++++++++++
 tb/tb_id_ex_stage_reg.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_reg_pkg.sv
// Shared pipeline constants: datapath width, EXE_CMD encodings and the NOP control word.
// Reused by the IF/ID, ID/EX and EX/MEM stage registers.
package id_ex_stage_reg_pkg;

  localparam int ADDRESS_LEN_DEF = 32;

  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;

  typedef struct packed {
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       b;
    logic       s;
    logic [3:0] exe_cmd;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // All-zero control word: no write-back, memory access, branch or flag update.
  localparam ctrl_t NOP_CTRL = '0;

endpackage

// File: rtl/id_ex_stage_reg_pipe_field_reg.sv
// Parameterised pipeline field register: async reset, hold (wins) and clear to a NOP value.
module pipe_field_reg #(
  parameter int           W       = 1,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_hold,
  input  logic         i_clear,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= CLR_VAL;
    end else if (!i_hold) begin
      r_q <= i_clear ? CLR_VAL : i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with freeze (hold) > flush > bubble > load priority.
// Optional macro ID_EX_FORWARDING_EN registers the source register numbers for forwarding.
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int ADDRESS_LEN = ADDRESS_LEN_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   flush,
  input  logic                   bubble,
  input  logic [ADDRESS_LEN-1:0] pc_in,
  input  logic                   wb_en_in,
  input  logic                   mem_r_en_in,
  input  logic                   mem_w_en_in,
  input  logic                   b_in,
  input  logic                   s_in,
  input  logic [3:0]             exe_cmd_in,
  input  logic [ADDRESS_LEN-1:0] val_rn_in,
  input  logic [ADDRESS_LEN-1:0] val_rm_in,
  input  logic                   imm_in,
  input  logic [11:0]            shift_operand_in,
  input  logic [23:0]            signed_imm_24_in,
  input  logic [3:0]             dest_in,
  input  logic [3:0]             sr_in,
  input  logic [3:0]             src1_in,
  input  logic [3:0]             src2_in,
  output logic [ADDRESS_LEN-1:0] pc_out,
  output logic                   wb_en_out,
  output logic                   mem_r_en_out,
  output logic                   mem_w_en_out,
  output logic                   b_out,
  output logic                   s_out,
  output logic [3:0]             exe_cmd_out,
  output logic [ADDRESS_LEN-1:0] val_rn_out,
  output logic [ADDRESS_LEN-1:0] val_rm_out,
  output logic                   imm_out,
  output logic [11:0]            shift_operand_out,
  output logic [23:0]            signed_imm_24_out,
  output logic [3:0]             dest_out,
  output logic [3:0]             sr_out,
  output logic [3:0]             src1_out,
  output logic [3:0]             src2_out,
  output logic                   valid_out
);

  localparam int DATA_W  = 3 * ADDRESS_LEN;
  localparam int FIELD_W = 1 + 12 + 24 + 4 + 4;

  // Flush and bubble both load the NOP state, so they share one clear.
  logic w_clear;
  assign w_clear = flush | bubble;

  ctrl_t             w_ctrl_d;
  ctrl_t             w_ctrl_q;
  logic              w_valid_q;
  logic [DATA_W-1:0] w_data_q;
  logic [FIELD_W-1:0] w_field_q;

  assign w_ctrl_d = '{wb_en: wb_en_in, mem_r_en: mem_r_en_in, mem_w_en: mem_w_en_in,
                      b: b_in, s: s_in, exe_cmd: exe_cmd_in};

  pipe_field_reg #(.W(CTRL_W + 1), .CLR_VAL({1'b0, NOP_CTRL})) u_ctrl_reg (
    .clk     (clk),
    .rst     (rst),
    .i_hold  (freeze),
    .i_clear (w_clear),
    .i_d     ({1'b1, w_ctrl_d}),
    .o_q     ({w_valid_q, w_ctrl_q})
  );

  pipe_field_reg #(.W(DATA_W)) u_data_reg (
    .clk     (clk),
    .rst     (rst),
    .i_hold  (freeze),
    .i_clear (w_clear),
    .i_d     ({pc_in, val_rn_in, val_rm_in}),
    .o_q     (w_data_q)
  );

  pipe_field_reg #(.W(FIELD_W)) u_field_reg (
    .clk     (clk),
    .rst     (rst),
    .i_hold  (freeze),
    .i_clear (w_clear),
    .i_d     ({imm_in, shift_operand_in, signed_imm_24_in, dest_in, sr_in}),
    .o_q     (w_field_q)
  );

  assign valid_out    = w_valid_q;
  assign wb_en_out    = w_ctrl_q.wb_en;
  assign mem_r_en_out = w_ctrl_q.mem_r_en;
  assign mem_w_en_out = w_ctrl_q.mem_w_en;
  assign b_out        = w_ctrl_q.b;
  assign s_out        = w_ctrl_q.s;
  assign exe_cmd_out  = w_ctrl_q.exe_cmd;

  assign {pc_out, val_rn_out, val_rm_out} = w_data_q;
  assign {imm_out, shift_operand_out, signed_imm_24_out, dest_out, sr_out} = w_field_q;

`ifdef ID_EX_FORWARDING_EN
  pipe_field_reg #(.W(8)) u_src_reg (
    .clk     (clk),
    .rst     (rst),
    .i_hold  (freeze),
    .i_clear (w_clear),
    .i_d     ({src1_in, src2_in}),
    .o_q     ({src1_out, src2_out})
  );
`else
  logic w_unused_src;
  assign w_unused_src = ^{src1_in, src2_in};
  assign src1_out = 4'd0;
  assign src2_out = 4'd0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed table-driven bench for id_ex_stage_reg, plus hand sequences for reset,
// write-back coherency and the ID_EX_FORWARDING_EN source fields.
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [8:0]  ctrl;   // {wb_en, mem_r_en, mem_w_en, b, s, exe_cmd[3:0]}
    logic        imm;
    logic [11:0] shift;
    logic [23:0] simm;
    logic [3:0]  dest;
    logic [3:0]  sr;
    logic [3:0]  src1;
    logic [3:0]  src2;
  } in_t;

  typedef struct packed {
    logic valid;
    in_t  d;
  } out_t;

  typedef struct {
    logic frz;
    logic fl;
    logic bb;
    in_t  d;
    out_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, freeze, flush, bubble;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
  logic [3:0]  exe_cmd_in, dest_in, sr_in, src1_in, src2_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic        wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out, valid_out;
  logic [3:0]  exe_cmd_out, dest_out, sr_out, src1_out, src2_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm_24_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] rf [16];

  always #5 clk = ~clk;

  id_ex_stage_reg #(.ADDRESS_LEN(32)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .bubble(bubble),
    .pc_in(pc_in), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .b_in(b_in), .s_in(s_in), .exe_cmd_in(exe_cmd_in),
    .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .imm_in(imm_in),
    .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
    .dest_in(dest_in), .sr_in(sr_in), .src1_in(src1_in), .src2_in(src2_in),
    .pc_out(pc_out), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .mem_w_en_out(mem_w_en_out), .b_out(b_out), .s_out(s_out), .exe_cmd_out(exe_cmd_out),
    .val_rn_out(val_rn_out), .val_rm_out(val_rm_out), .imm_out(imm_out),
    .shift_operand_out(shift_operand_out), .signed_imm_24_out(signed_imm_24_out),
    .dest_out(dest_out), .sr_out(sr_out), .src1_out(src1_out), .src2_out(src2_out),
    .valid_out(valid_out)
  );

  function automatic in_t mk_in(logic [31:0] pc, logic [31:0] rn, logic [31:0] rm,
                                logic [8:0] ctrl, logic imm, logic [11:0] shift,
                                logic [23:0] simm, logic [3:0] dest, logic [3:0] sr,
                                logic [3:0] s1, logic [3:0] s2);
    in_t v;
    v.pc = pc; v.rn = rn; v.rm = rm; v.ctrl = ctrl; v.imm = imm; v.shift = shift;
    v.simm = simm; v.dest = dest; v.sr = sr; v.src1 = s1; v.src2 = s2;
    return v;
  endfunction

  function automatic out_t ld(in_t d);
    out_t o;
    o.valid = 1'b1;
    o.d = d;
`ifndef ID_EX_FORWARDING_EN
    o.d.src1 = 4'd0;
    o.d.src2 = 4'd0;
`endif
    return o;
  endfunction

  function automatic out_t get_out();
    out_t o;
    o.valid = valid_out;
    o.d = mk_in(pc_out, val_rn_out, val_rm_out,
                {wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, exe_cmd_out},
                imm_out, shift_operand_out, signed_imm_24_out, dest_out, sr_out,
                src1_out, src2_out);
    return o;
  endfunction

  task automatic drive(input in_t d, input logic frz, input logic fl, input logic bb);
    pc_in = d.pc; val_rn_in = d.rn; val_rm_in = d.rm;
    {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, exe_cmd_in} = d.ctrl;
    imm_in = d.imm; shift_operand_in = d.shift; signed_imm_24_in = d.simm;
    dest_in = d.dest; sr_in = d.sr; src1_in = d.src1; src2_in = d.src2;
    freeze = frz; flush = fl; bubble = bb;
  endtask

  task automatic check(input string name, input out_t got, input out_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[16];
    in_t  a, bv, c, fl_i, ones;
    out_t zero;
    zero = '0;

    a    = mk_in(32'h0000_0008, 32'hDEAD_BEEF, 32'h0, 9'h100, 1'b0, 12'h0, 24'h0,
                 4'd4, 4'h0, 4'd0, 4'd0);
    bv   = mk_in(32'h0000_0010, 32'h1111_2222, 32'h3333_4444, 9'h112, 1'b1, 12'hABC,
                 24'hFF_FFFE, 4'hF, 4'hA, 4'd7, 4'd9);
    c    = mk_in(32'h0000_0014, 32'hCAFE_0000, 32'h0000_F00D, 9'h082, 1'b0, 12'h123,
                 24'h00_0800, 4'd2, 4'h4, 4'd3, 4'd5);
    fl_i = mk_in(32'h0000_0018, 32'h1234_5678, 32'h8765_4321, 9'h064, 1'b1, 12'h555,
                 24'h12_3456, 4'd6, 4'hF, 4'd1, 4'd2);
    ones = '1;

    vt[0]  = '{1'b0, 1'b0, 1'b0, a,    ld(a)};
    vt[1]  = '{1'b0, 1'b0, 1'b0, bv,   ld(bv)};
    vt[2]  = '{1'b1, 1'b0, 1'b0, c,    ld(bv)};
    vt[3]  = '{1'b1, 1'b0, 1'b0, c,    ld(bv)};
    vt[4]  = '{1'b1, 1'b0, 1'b0, c,    ld(bv)};
    vt[5]  = '{1'b0, 1'b0, 1'b0, c,    ld(c)};
    vt[6]  = '{1'b0, 1'b1, 1'b0, fl_i, zero};
    vt[7]  = '{1'b0, 1'b0, 1'b0, ones, ld(ones)};
    vt[8]  = '{1'b0, 1'b0, 1'b1, fl_i, zero};
    vt[9]  = '{1'b0, 1'b0, 1'b0, bv,   ld(bv)};
    vt[10] = '{1'b1, 1'b1, 1'b0, fl_i, ld(bv)};
    vt[11] = '{1'b0, 1'b1, 1'b1, fl_i, zero};
    vt[12] = '{1'b0, 1'b0, 1'b0, a,    ld(a)};
    vt[13] = '{1'b1, 1'b0, 1'b1, fl_i, ld(a)};
    vt[14] = '{1'b0, 1'b0, 1'b0, fl_i, ld(fl_i)};
    vt[15] = '{1'b0, 1'b1, 1'b0, ones, zero};

    // Reset state
    rst = 1'b1;
    drive('0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 check("reset_state", get_out(), zero);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      drive(vt[i].d, vt[i].frz, vt[i].fl, vt[i].bb);
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), get_out(), vt[i].exp);
      @(negedge clk);
    end

    // Async reset mid-cycle with non-zero inputs, no clock edge needed
    drive(bv, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 check("load_before_rst", get_out(), ld(bv));
    #1 rst = 1'b1;
    #1 check("async_rst", get_out(), zero);
    @(negedge clk);
    rst = 1'b0;

    // Reset during freeze still clears; first load on first edge after release
    drive(c, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    freeze = 1'b1;
    #2 rst = 1'b1;
    #1 check("rst_in_freeze", get_out(), zero);
    @(posedge clk);
    #1 check("rst_held_edge", get_out(), zero);
    @(negedge clk);
    rst = 1'b0;
    drive(a, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 check("first_load_after_rst", get_out(), ld(a));

    // Register file writes on the falling edge; this stage sees it on the next rise
    for (int r = 0; r < 16; r++) rf[r] = 32'h0;
    @(negedge clk);
    rf[3] = 32'h11;
    drive(c, 1'b0, 1'b0, 1'b0);
    src1_in = 4'd3;
    val_rn_in = rf[src1_in];
    @(posedge clk);
    #1 check32("rn_pre_wb", val_rn_out, 32'h11);
    @(negedge clk);
    rf[3] = 32'h55;
    val_rn_in = rf[src1_in];
    @(posedge clk);
    #1 check32("rn_after_wb", val_rn_out, 32'h55);

    // Source register numbers for the forwarding unit
    @(negedge clk);
    drive(c, 1'b0, 1'b0, 1'b0);
    src1_in = 4'd7;
    src2_in = 4'd9;
    @(posedge clk);
`ifdef ID_EX_FORWARDING_EN
    #1 check32("src_fwd", {24'h0, src1_out, src2_out}, {24'h0, 4'd7, 4'd9});
`else
    #1 check32("src_fwd", {24'h0, src1_out, src2_out}, 32'h0);
`endif
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 check32("src_flush", {24'h0, src1_out, src2_out}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
